// File: rtl/dffram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port DFF RAM with one-cycle read latency.
// Define DFFRAM_ARB_PERF_EN to build the saturating request-contention counter.
module dffram_arbiter #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              instr_req_i,
   input  logic [31:0]       instr_addr_i,
   output logic              instr_gnt_o,
   output logic              instr_rvalid_o,
   output logic [31:0]       instr_rdata_o,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [3:0]        data_be_i,
   input  logic [31:0]       data_addr_i,
   input  logic [31:0]       data_wdata_i,
   output logic              data_gnt_o,
   output logic              data_rvalid_o,
   output logic [31:0]       data_rdata_o,
   output logic              ram_en_o,
   output logic [3:0]        ram_we_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic [31:0]       ram_di_o,
   input  logic [31:0]       ram_do_i,
   output logic [15:0]       conflict_cnt_o
);

   typedef enum logic {
      PORT_DATA  = 1'b0,
      PORT_INSTR = 1'b1
   } port_e;

   port_e prio_q, prio_d;
   port_e rsp_port_q;
   logic  rsp_valid_q;
   logic  unused_addr;

   // Grants are held off during reset so nothing reaches the RAM while state is cleared.
   always_comb begin
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      if (rst_ni) begin
         if (instr_req_i && data_req_i) begin
            if (prio_q == PORT_DATA) data_gnt_o  = 1'b1;
            else                     instr_gnt_o = 1'b1;
         end else begin
            instr_gnt_o = instr_req_i;
            data_gnt_o  = data_req_i;
         end
      end

      prio_d = prio_q;
      if (data_gnt_o)       prio_d = PORT_INSTR;
      else if (instr_gnt_o) prio_d = PORT_DATA;

      ram_en_o = instr_gnt_o | data_gnt_o;
      ram_a_o  = data_gnt_o ? data_addr_i[ADDR_W+1:2] : instr_addr_i[ADDR_W+1:2];
      ram_we_o = (data_gnt_o && data_we_i) ? data_be_i : '0;
      ram_di_o = data_wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q      <= PORT_DATA;
         rsp_valid_q <= 1'b0;
         rsp_port_q  <= PORT_DATA;
      end else begin
         prio_q      <= prio_d;
         rsp_valid_q <= ram_en_o;
         if (ram_en_o) rsp_port_q <= data_gnt_o ? PORT_DATA : PORT_INSTR;
      end
   end

   assign instr_rvalid_o = rsp_valid_q && (rsp_port_q == PORT_INSTR);
   assign data_rvalid_o  = rsp_valid_q && (rsp_port_q == PORT_DATA);
   assign instr_rdata_o  = ram_do_i;
   assign data_rdata_o   = ram_do_i;

   // Byte offset and bits above the RAM window are ignored; addresses alias.
   assign unused_addr = ^{instr_addr_i[31:ADDR_W+2], instr_addr_i[1:0],
                          data_addr_i[31:ADDR_W+2], data_addr_i[1:0]};

`ifdef DFFRAM_ARB_PERF_EN
   logic [15:0] conflict_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         conflict_q <= '0;
      end else if (instr_req_i && data_req_i && (conflict_q != '1)) begin
         conflict_q <= conflict_q + 16'd1;
      end
   end

   assign conflict_cnt_o = conflict_q;
`else
   assign conflict_cnt_o = '0;
`endif

endmodule
